// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into accesses on a word-wide
// memory with a one-cycle registered read; sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_WR, S_RESP} state_e;

  typedef struct packed {
    logic             write;
    logic [1:0]       size;
    logic             uns;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;
    logic             err;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        misaligned;
  logic [31:0] merged;
  logic [31:0] extracted;
  logic        unused_addr;

  assign accept      = req_valid && (state_q == S_IDLE);
  assign misaligned  = (req_size == SZ_H && req_addr[0]) ||
                       (req_size == SZ_W && req_addr[1:0] != 2'b00) ||
                       (req_size == 2'b11);
  // Index wraps modulo memory depth: upper address bits are dropped.
  assign unused_addr = ^req_addr[31:IDX_W+2];

  // Per-byte merge: each lane takes the new store byte or keeps the old memory byte.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    logic hit;
    assign hit = (req_q.size == SZ_B && req_q.lane == LN) ||
                 (req_q.size == SZ_H && req_q.lane[1] == LN[1]);
    assign merged[8*i +: 8] = !hit ? mem_read_data[8*i +: 8] :
                              (req_q.size == SZ_B) ? req_q.wdata[7:0] :
                                                     req_q.wdata[8*(i%2) +: 8];
  end

  always_comb begin
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = mem_read_data >> {req_q.lane, 3'b000};
    half    = req_q.lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (req_q.size)
      SZ_B:    extracted = {{24{~req_q.uns & shifted[7]}}, shifted[7:0]};
      SZ_H:    extracted = {{16{~req_q.uns & half[15]}}, half};
      default: extracted = mem_read_data;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned)                     state_d = S_RESP;
          else if (req_write && req_size == SZ_W) state_d = S_WR;
          else                                state_d = S_RD;
        end
      end
      S_RD:    state_d = S_WT;
      S_WT:    state_d = req_q.write ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: request capture, merge of old word, load extraction
  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    if (accept) begin
      req_d.write = req_write;
      req_d.size  = req_size;
      req_d.uns   = req_unsigned;
      req_d.lane  = req_addr[1:0];
      req_d.idx   = req_addr[IDX_W+1:2];
      req_d.wdata = req_wdata;
      req_d.err   = misaligned;
      rdata_d     = '0;
    end else if (state_q == S_WT) begin
      if (req_q.write) req_d.wdata = merged;
      else             rdata_d     = extracted;
    end
  end

  // Outputs are decoded from the registered state, so reset clears strobes at once.
  always_comb begin
    req_ready        = (state_q == S_IDLE);
    mem_read_enable  = (state_q == S_RD);
    mem_write_enable = (state_q == S_WR);
    mem_address      = (state_q == S_IDLE) ? 32'd0 : {{(32-IDX_W){1'b0}}, req_q.idx};
    mem_write_data   = (state_q == S_WR) ? req_q.wdata : 32'd0;
    resp_valid       = (state_q == S_RESP);
    resp_rdata       = (state_q == S_RESP) ? rdata_q : 32'd0;
    resp_error       = (state_q == S_RESP) && req_q.err;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-organised data memory interface; sits between the core's execute stage and the data memory.
- Accepts byte/halfword/word load and store requests with RISC-V byte addresses.
- Converts each byte address to a word index and drives the memory's read and write strobes, honouring its one-cycle registered read.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores, because the memory has no byte enables.

Parameters:
- IDX_W, 8, width of the word index; the memory depth is 2^IDX_W words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted at a rising edge when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low 8/16/32 bits are used according to req_size.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  32  extended load data; 0 for stores and on error.
- resp_error  out  1  valid with resp_valid; misaligned or illegal size.
- mem_address  out  32  word index {zeros, req_addr[IDX_W+1:2]}.
- mem_write_data  out  32  merged word to write.
- mem_write_enable  out  1  memory write strobe.
- mem_read_enable  out  1  memory read strobe.
- mem_read_data  in  32  memory read port; valid the cycle after the edge that sampled mem_read_enable.

Behaviour:
- Reset (asynchronous): state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_error=0; all mem_* outputs 0. Reset mid-operation aborts the access. Because mem_write_enable clears immediately, no partial write occurs after reset assertion.
- Acceptance registers addr, size, unsigned, write and wdata. Inputs are ignored outside IDLE.
- Address bits above IDX_W+1 are ignored, so the index wraps modulo 2^IDX_W.
- Error check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or size=11. On error: IDLE->RESP, resp_error=1, resp_rdata=0, and no memory strobe is asserted.
- States: IDLE, RD, WT, WR, RESP.
  - Load: IDLE->RD->WT->RESP->IDLE. resp_valid is high in the 3rd cycle after the accepting edge. req_ready returns the cycle after.
  - Word store: IDLE->WR->RESP->IDLE. mem_write_data = wdata; the memory writes at the edge ending WR.
  - Sub-word store: IDLE->RD->WT->WR->RESP->IDLE (read-modify-write).
- Strobes per state:
  - RD: mem_read_enable=1, mem_write_enable=0.
  - WR: mem_write_enable=1, mem_read_enable=0.
  - Both are 0 in all other states. Read and write are never asserted in the same cycle.
  - mem_address is held stable from RD/WR entry through RESP.
- Load extraction: mem_read_data is sampled at the edge ending WT.
  - Byte: lane = addr[1:0], data = rdata[8*lane+7 : 8*lane].
  - Half: half = addr[1], data = rdata[16*half+15 : 16*half].
  - Extend to 32 bits by req_unsigned; word loads pass through unchanged.
- Store merge: the old word is captured at the edge ending WT.
  - Byte: replace lane addr[1:0] with wdata[7:0].
  - Half: replace half addr[1] with wdata[15:0].
  - All other bits are preserved.
- resp_valid deasserts after one cycle regardless of core state; there is no back-pressure on responses.
- Back-to-back requests: a new request can be accepted at the edge ending RESP+1 (IDLE). Minimum spacing is 3 cycles for a word store and 4 cycles for a load.

Test Plan:
- Reset with memory word 4 = 0x8899AABB, then load word addr 0x10 -> mem_address=4 and mem_read_enable for exactly one cycle; resp_valid 3 cycles after acceptance with resp_rdata=0x8899AABB, resp_error=0.
- Loads on the same word:
  - Byte addr 0x13, signed -> 0xFFFFFF88.
  - Byte addr 0x13, unsigned -> 0x00000088.
  - Half addr 0x10, signed -> 0xFFFFAABB.
- Store byte 0x5A to addr 0x11 -> RD, WT, then WR with mem_write_data=0x88995ABB; word 4 afterwards reads 0x88995ABB. Check that the two strobes never overlap.
- Misaligned requests:
  - Word store to addr 0x12 -> resp_valid the cycle after acceptance, resp_error=1, no mem strobes, memory unchanged.
  - Half load at addr 0x11 -> same error response.
  - req_size=11 -> same error response.
- Assert rst during the WR cycle of a word store to addr 0x20 -> mem_write_enable drops immediately, word 8 unchanged, and req_ready=1 after release.
- Hold req_valid during a load -> exactly one access is performed; the second request is accepted only in IDLE. Also cover addr 0x400 -> mem_address=0 (wrap).
